// File: rtl/onehot_chk_mon.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_chk_mon
//  Purpose  : Registered multi-channel one-hot checker / monitor. Each valid
//             beat carries NCH vectors of DW bits. Produces a per-channel
//             one-hot verdict and set-bit index one cycle later, plus
//             accumulated error statistics (sticky flags, saturating beat
//             counter, first-error capture).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i             in   1              clock, rising edge
//    rst_ni            in   1              asynchronous active-low reset
//    valid_i           in   1              data_i beat valid
//    data_i            in   NCH*DW         channel c at [c*DW +: DW]
//    clr_i             in   1              synchronous clear of statistics
//    valid_o           out  1              verdict valid (valid_i delayed 1)
//    is_onehot_o       out  NCH            per-channel one-hot verdict
//    index_o           out  NCH*IW         set-bit index, 0 if not one-hot
//    err_sticky_o      out  NCH            channel failed since reset/clear
//    err_cnt_o         out  CNT_W          failing-beat count, saturating
//    first_err_vld_o   out  1              first-error capture holds data
//    first_err_ch_o    out  $clog2(NCH)+1  lowest failing channel of 1st bad beat
//    first_err_data_o  out  DW             that channel's raw vector
// ============================================================================
module onehot_chk_mon #(
  parameter int DW    = 8,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  input  logic [NCH*DW-1:0]                 data_i,
  input  logic                              clr_i,
  output logic                              valid_o,
  output logic [NCH-1:0]                    is_onehot_o,
  output logic [NCH*$clog2(DW)-1:0]         index_o,
  output logic [NCH-1:0]                    err_sticky_o,
  output logic [CNT_W-1:0]                  err_cnt_o,
  output logic                              first_err_vld_o,
  output logic [$clog2(NCH):0]              first_err_ch_o,
  output logic [DW-1:0]                     first_err_data_o
);

  localparam int IW = $clog2(DW);
  localparam int PW = $clog2(DW + 1);
  localparam int CW = $clog2(NCH) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CAPT = 1'b1
  } state_t;

  logic [NCH-1:0]    w_fail;
  logic [NCH-1:0]    w_onehot;
  logic [NCH*IW-1:0] w_index;
  logic              w_any_fail;
  logic [CW-1:0]     w_low_ch;
  logic [DW-1:0]     w_low_data;
  logic              w_capture;
  state_t            w_state_nxt;

  state_t            r_state;
  logic              r_valid;
  logic [NCH-1:0]    r_onehot;
  logic [NCH*IW-1:0] r_index;
  logic [NCH-1:0]    r_sticky;
  logic [CNT_W-1:0]  r_cnt;
  logic [CW-1:0]     r_fe_ch;
  logic [DW-1:0]     r_fe_data;

  // Per-channel popcount and set-bit position
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] w_vec;
    logic [PW-1:0] w_pop;
    logic [IW-1:0] w_pos;

    assign w_vec = data_i[c*DW +: DW];

    // w_pos ends up at the highest set bit; only used when exactly one is set
    always_comb begin
      w_pop = '0;
      w_pos = '0;
      for (int b = 0; b < DW; b++) begin
        w_pop = w_pop + PW'(w_vec[b]);
        if (w_vec[b]) w_pos = IW'(b);
      end
    end

    assign w_onehot[c]          = (w_pop == PW'(1));
    assign w_fail[c]            = (MODE == 0) ? (w_pop != PW'(1)) : (w_pop > PW'(1));
    assign w_index[c*IW +: IW]  = w_onehot[c] ? w_pos : '0;
  end

  assign w_any_fail = valid_i & (|w_fail);

  // Lowest failing channel: scan downward so the last hit is the lowest index
  always_comb begin
    w_low_ch   = '0;
    w_low_data = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_fail[c]) begin
        w_low_ch   = CW'(c);
        w_low_data = data_i[c*DW +: DW];
      end
    end
  end

  // First-error capture FSM: clear has priority over a same-cycle failure
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (clr_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_fail) begin
            w_state_nxt = ST_CAPT;
            w_capture   = 1'b1;
          end
        end
        ST_CAPT: w_state_nxt = ST_CAPT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid   <= 1'b0;
      r_onehot  <= '0;
      r_index   <= '0;
      r_sticky  <= '0;
      r_cnt     <= '0;
      r_fe_ch   <= '0;
      r_fe_data <= '0;
    end else begin
      r_valid <= valid_i;
      // Verdict is produced even for a beat that coincides with clr_i
      if (valid_i) begin
        r_onehot <= w_onehot;
        r_index  <= w_index;
      end
      if (clr_i) begin
        r_sticky  <= '0;
        r_cnt     <= '0;
        r_fe_ch   <= '0;
        r_fe_data <= '0;
      end else begin
        if (valid_i) begin
          r_sticky <= r_sticky | w_fail;
        end
        if (w_any_fail && !(&r_cnt)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_capture) begin
          r_fe_ch   <= w_low_ch;
          r_fe_data <= w_low_data;
        end
      end
    end
  end

  assign valid_o          = r_valid;
  assign is_onehot_o      = r_onehot;
  assign index_o          = r_index;
  assign err_sticky_o     = r_sticky;
  assign err_cnt_o        = r_cnt;
  assign first_err_vld_o  = (r_state == ST_CAPT);
  assign first_err_ch_o   = r_fe_ch;
  assign first_err_data_o = r_fe_data;

endmodule
`default_nettype wire

// File: tb/tb_onehot_chk_mon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_chk_mon
//  Purpose  : Bench for onehot_chk_mon. Three instances share one stimulus
//             stream: strict mode, one-hot-or-zero mode, and strict mode with
//             a 3-bit counter. A behavioural model tracks each instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_onehot_chk_mon;

  localparam int NK = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] data  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // DUT outputs
  logic        v0, v1, v2;
  logic [3:0]  oh0, oh1, oh2;
  logic [11:0] idx0, idx1, idx2;
  logic [3:0]  st0, st1, st2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        fv0, fv1, fv2;
  logic [2:0]  fch0, fch1, fch2;
  logic [7:0]  fd0, fd1, fd2;

  onehot_chk_mon #(.DW(8), .NCH(4), .MODE(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v0), .is_onehot_o(oh0), .index_o(idx0), .err_sticky_o(st0),
    .err_cnt_o(cnt0), .first_err_vld_o(fv0), .first_err_ch_o(fch0),
    .first_err_data_o(fd0));

  onehot_chk_mon #(.DW(8), .NCH(4), .MODE(1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v1), .is_onehot_o(oh1), .index_o(idx1), .err_sticky_o(st1),
    .err_cnt_o(cnt1), .first_err_vld_o(fv1), .first_err_ch_o(fch1),
    .first_err_data_o(fd1));

  onehot_chk_mon #(.DW(8), .NCH(4), .MODE(0), .CNT_W(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v2), .is_onehot_o(oh2), .index_o(idx2), .err_sticky_o(st2),
    .err_cnt_o(cnt2), .first_err_vld_o(fv2), .first_err_ch_o(fch2),
    .first_err_data_o(fd2));

  // ---------------- behavioural model ----------------
  logic        m_valid [NK];
  logic [3:0]  m_oh    [NK];
  logic [11:0] m_idx   [NK];
  logic [3:0]  m_st    [NK];
  int          m_cnt   [NK];
  logic        m_fv    [NK];
  int          m_fch   [NK];
  logic [7:0]  m_fd    [NK];

  function automatic int pos_of(logic [7:0] v);
    logic [7:0] one;
    one = 8'd1;
    for (int b = 0; b < 8; b++) if (v == (one << b)) return b;
    return 0;
  endfunction

  task automatic model_clear(int k);
    m_st[k]  = '0;
    m_cnt[k] = 0;
    m_fv[k]  = 1'b0;
    m_fch[k] = 0;
    m_fd[k]  = '0;
  endtask

  task automatic model_step(int k);
    logic [3:0] fails;
    logic [7:0] v;
    int         n, low, cmax;
    logic       ok1, is_zero_ok;
    is_zero_ok = (k == 1);
    cmax       = (k == 2) ? 7 : 65535;
    fails = '0;
    low   = -1;
    for (int c = 0; c < 4; c++) begin
      v   = data[c*8 +: 8];
      n   = $countones(v);
      ok1 = (n == 1);
      fails[c] = is_zero_ok ? (n > 1) : (n != 1);
      if (valid) begin
        m_oh[k][c]         = ok1;
        m_idx[k][c*3 +: 3] = ok1 ? 3'(pos_of(v)) : 3'd0;
      end
      if (fails[c] && low < 0) low = c;
    end
    m_valid[k] = valid;
    if (clr) begin
      model_clear(k);
    end else if (valid) begin
      m_st[k] = m_st[k] | fails;
      if (fails != 0) begin
        if (m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
        if (!m_fv[k]) begin
          m_fv[k]  = 1'b1;
          m_fch[k] = low;
          m_fd[k]  = data[low*8 +: 8];
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        m_valid[k] = 1'b0;
        m_oh[k]    = '0;
        m_idx[k]   = '0;
        model_clear(k);
      end
    end else begin
      for (int k = 0; k < NK; k++) model_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s actual=%0h required=%0h t=%0t", k, nm, act, exp, $time);
    end
  endtask

  task automatic chk_dut(int k, logic v, logic [3:0] oh, logic [11:0] idx,
                         logic [3:0] st, logic [31:0] cnt, logic fv,
                         logic [2:0] fch, logic [7:0] fd);
    chk(k, "valid_o",    32'(v),   32'(m_valid[k]));
    chk(k, "is_onehot",  32'(oh),  32'(m_oh[k]));
    chk(k, "index",      32'(idx), 32'(m_idx[k]));
    chk(k, "sticky",     32'(st),  32'(m_st[k]));
    chk(k, "err_cnt",    cnt,      32'(m_cnt[k]));
    chk(k, "fe_vld",     32'(fv),  32'(m_fv[k]));
    chk(k, "fe_ch",      32'(fch), 32'(m_fch[k]));
    chk(k, "fe_data",    32'(fd),  32'(m_fd[k]));
  endtask

  always @(negedge clk) begin
    chk_dut(0, v0, oh0, idx0, st0, 32'(cnt0), fv0, fch0, fd0);
    chk_dut(1, v1, oh1, idx1, st1, 32'(cnt1), fv1, fch1, fd1);
    chk_dut(2, v2, oh2, idx2, st2, 32'(cnt2), fv2, fch2, fd2);
  end

  // ---------------- stimulus ----------------
  task automatic step(logic v, logic [31:0] d, logic c);
    valid = v;
    data  = d;
    clr   = c;
    @(negedge clk);
  endtask

  function automatic logic [7:0] gen_ch();
    logic [7:0] one;
    one = 8'd1;
    case ($urandom_range(0, 3))
      0, 3:    return one << $urandom_range(0, 7);
      1:       return 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk(0, "rst_valid", 32'(v0),   32'd0);
    chk(0, "rst_cnt",   32'(cnt0), 32'd0);
    chk(0, "rst_fevld", 32'(fv0),  32'd0);
    rst_n = 1'b1;

    // All channels one-hot
    step(1'b1, 32'h80011004, 1'b0);
    chk(0, "t2_valid", 32'(v0),   32'd1);
    chk(0, "t2_oh",    32'(oh0),  32'hF);
    chk(0, "t2_idx",   32'(idx0), 32'hE22);
    chk(0, "t2_cnt",   32'(cnt0), 32'd0);

    // ch1 zero, ch3 two bits
    step(1'b1, 32'h06020001, 1'b0);
    chk(0, "t3_oh",     32'(oh0),  32'h5);
    chk(0, "t3_sticky", 32'(st0),  32'hA);
    chk(0, "t3_cnt",    32'(cnt0), 32'd1);
    chk(0, "t3_fech",   32'(fch0), 32'd1);
    chk(0, "t3_fedata", 32'(fd0),  32'h00);

    step(1'b1, 32'h0C020001, 1'b0);
    chk(0, "t3b_cnt",    32'(cnt0), 32'd2);
    chk(0, "t3b_fech",   32'(fch0), 32'd1);
    chk(0, "t3b_fedata", 32'(fd0),  32'h00);

    // No beat: verdict holds, valid drops
    step(1'b0, 32'h0C020001, 1'b0);
    chk(0, "hold_valid", 32'(v0),   32'd0);
    chk(0, "hold_oh",    32'(oh0),  32'h5);
    chk(0, "hold_cnt",   32'(cnt0), 32'd2);

    // One-hot-or-zero mode
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h08040200, 1'b0);
    chk(1, "t4_cnt",    32'(cnt1), 32'd0);
    chk(1, "t4_oh",     32'(oh1),  32'hE);
    chk(1, "t4_sticky", 32'(st1),  32'h0);
    step(1'b1, 32'h080402FF, 1'b0);
    chk(1, "t4b_sticky", 32'(st1),  32'h1);
    chk(1, "t4b_cnt",    32'(cnt1), 32'd1);
    chk(1, "t4b_fedata", 32'(fd1),  32'hFF);

    // Counter saturation on the 3-bit instance
    step(1'b0, 32'h0, 1'b1);
    repeat (9) step(1'b1, 32'h00000000, 1'b0);
    chk(2, "t5_cnt",    32'(cnt2), 32'd7);
    chk(2, "t5_fevld",  32'(fv2),  32'd1);
    chk(2, "t5_sticky", 32'(st2),  32'hF);

    // Clear together with a failing beat
    step(1'b1, 32'h00000003, 1'b1);
    chk(2, "t5b_cnt",   32'(cnt2), 32'd0);
    chk(2, "t5b_fevld", 32'(fv2),  32'd0);
    chk(2, "t5b_valid", 32'(v2),   32'd1);
    chk(2, "t5b_oh",    32'(oh2),  32'h0);

    // Asynchronous reset mid-stream
    step(1'b1, 32'h06020001, 1'b0);
    chk(0, "t1_pre_cnt", 32'(cnt0), 32'd1);
    valid = 1'b1;
    data  = 32'h80011004;
    #3 rst_n = 1'b0;
    #1;
    chk(0, "t1_valid",  32'(v0),   32'd0);
    chk(0, "t1_oh",     32'(oh0),  32'd0);
    chk(0, "t1_idx",    32'(idx0), 32'd0);
    chk(0, "t1_sticky", 32'(st0),  32'd0);
    chk(0, "t1_cnt",    32'(cnt0), 32'd0);
    chk(0, "t1_fevld",  32'(fv0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk(0, "t1_post_valid", 32'(v0), 32'd0);

    // Random beats with toggling valid and occasional clear
    repeat (300) begin
      step(1'($urandom_range(0, 1)),
           {gen_ch(), gen_ch(), gen_ch(), gen_ch()},
           1'($urandom_range(0, 19) == 0));
    end
    step(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
